// File: rtl/serial_boot_loader.sv
// Deserialises a framed boot image (header N, N payload words, checksum) from a strobe/data pin pair into memory writes.
// A bit lands SYNC_STAGES+1 clocks after its strobe edge; writes are single-cycle pulses with no backpressure.
module serial_boot_loader #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_data_clk,
  input  logic              i_data_pin,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_error_code,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]   DEPTH_N  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        ERR_NONE = 2'b00;
  localparam logic [1:0]        ERR_TMO  = 2'b01;
  localparam logic [1:0]        ERR_CSUM = 2'b10;
  localparam logic [1:0]        ERR_HDR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_pin_sync;
  logic                   r_clk_prev;
  logic [WORD_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [TMO_W-1:0]       r_tmo;
  logic [WORD_W-1:0]      r_csum;
  logic [ADDR_W:0]        r_n;
  logic [ADDR_W:0]        r_word_count;
  logic                   r_wr_en;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [WORD_W-1:0]      r_wr_data;
  logic [1:0]             r_err_code;

  logic              w_edge;
  logic              w_bit;
  logic              w_active;
  logic              w_shift_in;
  logic              w_word_done;
  logic              w_timeout;
  logic [WORD_W-1:0] w_word;
  logic [ADDR_W:0]   w_hdr_n;
  logic              w_hdr_bad;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_wr_fire;
  logic              w_hdr_take;
  logic              w_err_set;
  logic [1:0]        w_err_code_nxt;

  assign w_edge      = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_bit       = r_pin_sync[SYNC_STAGES-1];
  assign w_active    = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_shift_in  = i_enable && w_edge && ((r_state == S_IDLE) || w_active);
  assign w_word      = {r_shift[WORD_W-2:0], w_bit};
  assign w_word_done = w_shift_in && (r_bit_cnt == CNT_W'(WORD_W - 1));
  // An edge in the expiry cycle restarts the count instead of aborting.
  assign w_timeout   = w_active && !w_edge && (r_tmo == TMO_W'(TIMEOUT));
  assign w_hdr_n     = w_word[ADDR_W:0];
  assign w_hdr_bad   = (|(w_word >> (ADDR_W + 1))) || (w_hdr_n > DEPTH_N);
  assign w_cnt_inc   = r_word_count + (ADDR_W + 1)'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_fire      = 1'b0;
    w_hdr_take     = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_edge) w_state_nxt = S_HDR;
        end
        S_HDR: begin
          if (w_timeout) begin
            w_state_nxt    = S_ERROR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_TMO;
          end else if (w_word_done) begin
            w_hdr_take = 1'b1;
            if (w_hdr_bad) begin
              w_state_nxt    = S_ERROR;
              w_err_set      = 1'b1;
              w_err_code_nxt = ERR_HDR;
            end else if (w_hdr_n == '0) begin
              w_state_nxt = S_CHECK;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_timeout) begin
            w_state_nxt    = S_ERROR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_TMO;
          end else if (w_word_done) begin
            w_wr_fire = 1'b1;
          end else if (r_wr_en && (r_word_count == r_n)) begin
            // Leave only after the final pulse so wr_en stays confined to LOAD.
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_timeout) begin
            w_state_nxt    = S_ERROR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_TMO;
          end else if (w_word_done) begin
            if (w_word == r_csum) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt    = S_ERROR;
              w_err_set      = 1'b1;
              w_err_code_nxt = ERR_CSUM;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_clk_sync   <= '0;
      r_pin_sync   <= '0;
      r_clk_prev   <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_tmo        <= '0;
      r_csum       <= '0;
      r_n          <= '0;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_data_clk};
      r_pin_sync <= {r_pin_sync[SYNC_STAGES-2:0], i_data_pin};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      if (!i_enable) begin
        r_shift      <= '0;
        r_bit_cnt    <= '0;
        r_tmo        <= '0;
        r_csum       <= '0;
        r_n          <= '0;
        r_word_count <= '0;
        r_wr_en      <= 1'b0;
        r_err_code   <= ERR_NONE;
      end else begin
        r_wr_en <= w_wr_fire;
        if (w_err_set) begin
          r_err_code <= w_err_code_nxt;
        end
        if (w_timeout) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else if (w_shift_in) begin
          r_shift   <= w_word;
          r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
        end
        if (w_edge || !w_active) begin
          r_tmo <= '0;
        end else if (r_tmo != TMO_W'(TIMEOUT)) begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
        if (w_hdr_take) begin
          r_n          <= w_hdr_n;
          r_csum       <= '0;
          r_word_count <= '0;
        end
        if (w_wr_fire) begin
          r_wr_addr    <= BASE_A + r_word_count[ADDR_W-1:0];
          r_wr_data    <= w_word;
          r_word_count <= w_cnt_inc;
          r_csum       <= r_csum + w_word;
        end
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign o_done       = (r_state == S_DONE);
  assign o_error      = (r_state == S_ERROR);
  assign o_error_code = r_err_code;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_serial_boot_loader.sv
// Directed bench for serial_boot_loader: framed images sent bit by bit, writes logged and compared to hand-computed values.
module tb_serial_boot_loader;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        data_clk = 1'b0;
  logic        data_pin = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;
  logic [12:0] word_count;

  int errors = 0;
  int checks = 0;
  int wr_n = 0;
  int stray = 0;
  logic [11:0] wa [8];
  logic [31:0] wd [8];

  serial_boot_loader #(
    .WORD_W(32), .ADDR_W(12), .BASE_ADDR(0), .SYNC_STAGES(2), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_data_clk(data_clk), .i_data_pin(data_pin),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_done(done),
    .o_error(error), .o_error_code(error_code), .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_n < 8) begin
        wa[wr_n] = wr_addr;
        wd[wr_n] = wr_data;
      end
      wr_n++;
      if (!busy) stray++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    @(negedge clk); data_pin = b; data_clk = 1'b0;
    @(negedge clk); data_clk = 1'b1;
    @(negedge clk);
    @(negedge clk); data_clk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic rearm();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); wr_n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 12'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 000", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
    checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL reset_code: got %b want 00", error_code); end
    checks++; if (word_count !== 13'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
    reset = 1'b1;
    @(negedge clk); wr_n = 0;
  endtask

  task automatic test_good_frame();
    rearm();
    send_word(32'h00000003);
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_hdr: got %b want 1", busy); end
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h66666666);
    settle();
    checks++; if (wr_n !== 3) begin errors++; $display("FAIL good_writes: got %0d want 3", wr_n); end
    checks++; if (wa[0] !== 12'd0 || wa[1] !== 12'd1 || wa[2] !== 12'd2) begin errors++; $display("FAIL good_addrs: got %h %h %h want 000 001 002", wa[0], wa[1], wa[2]); end
    checks++; if (wd[0] !== 32'h11111111 || wd[1] !== 32'h22222222 || wd[2] !== 32'h33333333) begin errors++; $display("FAIL good_data: got %h %h %h want 11111111 22222222 33333333", wd[0], wd[1], wd[2]); end
    checks++; if ({busy, done, error} !== 3'b010) begin errors++; $display("FAIL good_flags: got %b want 010", {busy, done, error}); end
    checks++; if (word_count !== 13'd3) begin errors++; $display("FAIL good_count: got %0d want 3", word_count); end
    checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL good_code: got %b want 00", error_code); end
  endtask

  task automatic test_ignore_after_done();
    send_word(32'h00000001);
    send_word(32'h12345678);
    settle();
    checks++; if (wr_n !== 3 || done !== 1'b1 || word_count !== 13'd3) begin errors++; $display("FAIL after_done: writes %0d done %b count %0d want 3 1 3", wr_n, done, word_count); end
  endtask

  task automatic test_bad_checksum();
    rearm();
    send_word(32'h00000003);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h66666667);
    settle();
    checks++; if (wr_n !== 3) begin errors++; $display("FAIL csum_writes: got %0d want 3", wr_n); end
    checks++; if ({busy, done, error} !== 3'b001) begin errors++; $display("FAIL csum_flags: got %b want 001", {busy, done, error}); end
    checks++; if (error_code !== 2'b10) begin errors++; $display("FAIL csum_code: got %b want 10", error_code); end
  endtask

  task automatic test_checksum_wrap();
    rearm();
    send_word(32'h00000002);
    send_word(32'hFFFFFFFF);
    send_word(32'h00000002);
    send_word(32'h00000001);
    settle();
    checks++; if (done !== 1'b1 || error !== 1'b0 || wr_n !== 2) begin errors++; $display("FAIL wrap: done %b error %b writes %0d want 1 0 2", done, error, wr_n); end
    checks++; if (wd[1] !== 32'h00000002 || wa[1] !== 12'd1) begin errors++; $display("FAIL wrap_second: got %h@%h want 00000002@001", wd[1], wa[1]); end
  endtask

  task automatic test_empty_frame();
    rearm();
    send_word(32'h00000000);
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b want 1", busy); end
    send_word(32'h00000000);
    settle();
    checks++; if (wr_n !== 0 || done !== 1'b1 || word_count !== 13'd0) begin errors++; $display("FAIL empty: writes %0d done %b count %0d want 0 1 0", wr_n, done, word_count); end
  endtask

  task automatic test_bad_header();
    rearm();
    send_word(32'h00001001);
    settle();
    checks++; if (error !== 1'b1 || error_code !== 2'b11 || busy !== 1'b0) begin errors++; $display("FAIL hdr_depth: error %b code %b busy %b want 1 11 0", error, error_code, busy); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL hdr_depth_writes: got %0d want 0", wr_n); end
    rearm();
    checks++; if (error !== 1'b0 || error_code !== 2'b00) begin errors++; $display("FAIL rearm_clears: error %b code %b want 0 00", error, error_code); end
    send_word(32'h80000001);
    settle();
    checks++; if (error !== 1'b1 || error_code !== 2'b11 || wr_n !== 0) begin errors++; $display("FAIL hdr_upper: error %b code %b writes %0d want 1 11 0", error, error_code, wr_n); end
  endtask

  task automatic test_timeout();
    rearm();
    send_word(32'h00000002);
    send_word(32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (TMO - 20) @(negedge clk);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: error %b busy %b want 0 1", error, busy); end
    repeat (40) @(negedge clk);
    checks++; if (error !== 1'b1 || error_code !== 2'b01) begin errors++; $display("FAIL tmo_code: error %b code %b want 1 01", error, error_code); end
    checks++; if (word_count !== 13'd1 || wr_n !== 1) begin errors++; $display("FAIL tmo_count: count %0d writes %0d want 1 1", word_count, wr_n); end
    checks++; if (wd[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL tmo_data: got %h want a5a5a5a5", wd[0]); end
  endtask

  task automatic full_frame_after_abort(input string tag);
    send_word(32'h00000003);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h66666666);
    settle();
    checks++; if (wr_n !== 3 || wa[0] !== 12'd0 || wa[2] !== 12'd2 || wd[2] !== 32'h33333333) begin errors++; $display("FAIL %s_refill: writes %0d a0 %h a2 %h d2 %h want 3 000 002 33333333", tag, wr_n, wa[0], wa[2], wd[2]); end
    checks++; if (done !== 1'b1 || word_count !== 13'd3) begin errors++; $display("FAIL %s_done: done %b count %0d want 1 3", tag, done, word_count); end
  endtask

  task automatic test_reset_mid_load();
    rearm();
    send_word(32'h00000003);
    send_word(32'hDEADBEEF);
    settle();
    checks++; if (wr_n !== 1 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: writes %0d busy %b want 1 1", wr_n, busy); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if ({wr_en, busy, done, error} !== 4'b0000 || word_count !== 13'd0 || wr_addr !== 12'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rst_mid_clear: flags %b count %0d addr %h data %h want 0000 0 000 0", {wr_en, busy, done, error}, word_count, wr_addr, wr_data); end
    reset = 1'b1;
    @(negedge clk); wr_n = 0;
    full_frame_after_abort("rst");
  endtask

  task automatic test_enable_mid_load();
    rearm();
    send_word(32'h00000003);
    send_word(32'hCAFEF00D);
    settle();
    checks++; if (wr_n !== 1 || word_count !== 13'd1) begin errors++; $display("FAIL en_mid_pre: writes %0d count %0d want 1 1", wr_n, word_count); end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++; if ({wr_en, busy, done, error} !== 4'b0000 || word_count !== 13'd0 || error_code !== 2'b00) begin errors++; $display("FAIL en_mid_clear: flags %b count %0d code %b want 0000 0 00", {wr_en, busy, done, error}, word_count, error_code); end
    enable = 1'b1;
    @(negedge clk); wr_n = 0;
    full_frame_after_abort("en");
  endtask

  task automatic test_no_stray_writes();
    checks++; if (stray !== 0) begin errors++; $display("FAIL stray_writes: got %0d writes outside busy want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_ignore_after_done();
    test_bad_checksum();
    test_checksum_wrap();
    test_empty_frame();
    test_bad_header();
    test_timeout();
    test_reset_mid_load();
    test_enable_mid_load();
    test_no_stray_writes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_boot_loader.md
Name: serial_boot_loader

Overview:
Parametrised successor to the single-word bootloader receiver. It deserialises a framed program image from an external bit-strobe/data pin pair into a memory write port. The frame carries a word-count header, payload words and a checksum trailer. It sits in the FPGA top level between the bootloader pins and the instruction ROM write port, and is armed while the CPU is held in reset.

Parameters:
WORD_W, 32, bits per word (header, payload, checksum); must be > ADDR_W
ADDR_W, 12, memory address width; max payload DEPTH = 2^ADDR_W words
BASE_ADDR, 0, address of first payload word
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
TIMEOUT, 100000, clk cycles allowed between strobe edges once a frame has started

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  loader armed; low forces IDLE and suppresses writes
data_clk  in  1  external bit strobe, asynchronous to clk; bit taken on its rising edge
data_pin  in  1  external serial data, MSB first
wr_en  out  1  one-cycle memory write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  WORD_W  write data
busy  out  1  frame in progress (LOAD or CHECK)
done  out  1  frame loaded, checksum good; held
error  out  1  frame aborted; held
error_code  out  2  01 timeout, 10 checksum mismatch, 11 bad header, 00 none
word_count  out  ADDR_W+1  payload words written this frame

Behaviour:
- Reset (reset==0 at clk rise): all outputs 0, state IDLE, shift register/bit counter/timeout/checksum cleared. Reset dominates every other event, including mid-frame.
- Input path: data_clk and data_pin each pass through a SYNC_STAGES flop chain. Rising edge is detected on the synchronised strobe (prev 0, current 1). The bit sampled is the synchronised data_pin at that cycle. Strobe edge to bit captured = SYNC_STAGES+1 clk cycles.
- Shifter: WORD_W-bit left shift, MSB first. The bit counter wraps at WORD_W, and a word is complete on the WORD_W-th bit.
- States:
  - IDLE: enable==1 and first strobe edge -> HDR (busy stays 0 until header completes).
  - HDR: on word complete, N = word[ADDR_W:0]. If upper bits [WORD_W-1:ADDR_W+1] are non-zero or N > DEPTH -> ERROR code 11. If N==0 -> CHECK. Otherwise -> LOAD. Checksum accumulator is cleared.
  - LOAD: each completed word produces a wr_en pulse the next cycle, with wr_data = word and wr_addr = BASE_ADDR + word_count (mod 2^ADDR_W). word_count increments in the same cycle. Checksum += word (mod 2^WORD_W). After the Nth write -> CHECK.
  - CHECK: on word complete, equal to checksum -> DONE; else -> ERROR code 10.
  - DONE: done=1 and busy=0. Further strobes are ignored.
  - ERROR: error=1 and busy=0. Further strobes are ignored.
- busy=1 in LOAD and CHECK.
- enable==0 in any state -> IDLE next cycle. done, error, error_code, word_count and partial word are cleared, and no wr_en is issued that cycle even if a word completes simultaneously.
- Re-arming: enable low then high starts a fresh frame from BASE_ADDR.
- Timeout: counter clears on each strobe edge and counts in HDR/LOAD/CHECK. When it reaches TIMEOUT -> ERROR code 01 and the partial word is discarded. Writes already issued stand; word_count reports them.
- Simultaneous strobe edge and timeout expiry in the same cycle: the edge wins (counter clears).
- wr_en is never asserted outside LOAD. At most one write per WORD_W strobes.

Test Plan:
- N=3 header 0x00000003, payload 0x11111111, 0x22222222, 0x33333333, checksum 0x66666666 -> 3 wr_en pulses at addr 0, 1, 2 with matching data; done=1, error=0, word_count=3.
- Same frame with checksum 0x66666667 -> 3 writes, then error=1, error_code=10, done=0.
- Header 0x00000000, checksum 0x00000000 -> no wr_en, done=1, word_count=0.
- Header 0x00001001 (ADDR_W=12, N=4097) -> error_code=11 right after header, no writes; 0x80000001 -> error_code=11.
- N=2: word 1 sent, then 5 bits of word 2, then no strobes for TIMEOUT+1 cycles -> error_code=01, word_count=1, no second write.
- reset=0 for one cycle mid-LOAD (after 1 write) -> all outputs 0 next cycle; a subsequent full N=3 frame writes from addr 0 and sets done. Repeat with enable dropped instead of reset -> same outcome.
